regfile_seq: RTL and testbench
==============================

# regfile_seq

Command sequencer for the 4-entry × 8-bit register file. It accepts WRITE, READ and ADD commands over a valid/ready handshake. It drives the write-side demultiplexers (data routing and store-strobe routing) and the read-side 4:1 multiplexer, then returns one response per command. It sits between the command source and the register-file datapath; the storage registers, demuxes and mux are siblings at the top level, not inside this block.

## Interface
- DATA_W, 8, register and data width; register count fixed at 4 (2-bit select)
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command
- cmd_op  input  2  00 NOP, 01 WRITE, 10 READ, 11 ADD
- cmd_addr  input  2  target register 0–3
- cmd_wdata  input  DATA_W  write data / ADD operand
- wr_sel  output  2  select to data demux and store demux
- wr_data  output  DATA_W  data into data demux
- wr_store  output  1  store strobe into store demux
- rd_sel  output  2  mux select
- rd_en_n  output  1  mux enable, active-low (mux outputs 0 when high)
- rd_y  input  DATA_W  mux output, combinational from rd_sel/rd_en_n
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumer ready
- rsp_data  output  DATA_W  result
- rsp_carry  output  1  ADD carry-out; 0 for other ops

## Operation
- States: IDLE, READ, WRITE, RESP.
- cmd_ready is 1 only in IDLE and only when reset is low.
- A command is accepted on a cycle with cmd_valid && cmd_ready. On acceptance, op, addr and wdata are latched.
- From IDLE on accept:
  - NOP: stay in IDLE; no response is produced.
  - WRITE: go to WRITE.
  - READ or ADD: go to READ.
- READ state (one cycle):
  - rd_sel = latched addr, rd_en_n = 0.
  - rd_y is captured into the operand register at the clock edge.
  - Next state: WRITE if op = ADD, otherwise RESP.
- WRITE state (one cycle):
  - wr_sel = addr, wr_store = 1.
  - wr_data = wdata for WRITE; (operand + wdata) mod 2^DATA_W for ADD.
  - Next state: RESP.
- RESP state:
  - rsp_valid = 1; rsp_data/rsp_carry are held stable until rsp_ready.
  - rsp_data = wdata for WRITE, captured operand for READ, sum for ADD.
  - rsp_carry = bit DATA_W of operand + wdata for ADD, 0 otherwise.
  - On rsp_valid && rsp_ready, go to IDLE.
- Outside their active states: wr_store = 0, wr_data = 0, wr_sel = 0, rd_en_n = 1, rd_sel = 0.
- ADD with wrap-around: 0xF0 + 0x20 gives 0x10 with carry 1.
- ADD to the same address as a preceding WRITE must see the written value. This holds because storage updates at the end of the WRITE cycle and the next READ occurs at least 2 cycles later.

## Timing
- Reset values: state IDLE, cmd_ready 0 during reset and 1 the cycle after, all other outputs 0, rd_en_n 1.
- Latency from accept edge to rsp_valid high: WRITE 2 cycles, READ 2, ADD 3.
- wr_store is a single-cycle pulse, exactly once per WRITE/ADD, never for READ/NOP.
- No new command is accepted in the cycle rsp_valid && rsp_ready. The earliest next accept is the following cycle in IDLE.
- Back-to-back throughput: one command per 3 cycles (WRITE/READ) or 4 cycles (ADD) with rsp_ready held high.
- Reset asserted in any state: next cycle IDLE, the in-flight command is dropped, no wr_store pulse, no response.
- Backpressure: rsp_ready low holds RESP indefinitely; outputs remain constant.

## Structure
- Shared package regfile_pkg: DATA_W default, op codes (OP_NOP, OP_WRITE, OP_READ, OP_ADD), state encoding, and REG_ADDR_W = 2.
- Single module; no sub-module. The adder is inline.
- At the top level, wr_sel/wr_data feed the data demux, wr_sel/wr_store feed the store demux, and rd_sel/rd_en_n/rd_y connect to the 4:1 mux.

## Test plan
- Reset, then WRITE addr 2 data 0x5A → one wr_store pulse with wr_sel = 2, wr_data = 0x5A; rsp_data = 0x5A, rsp_carry = 0, rsp_valid exactly 2 cycles after accept.
- WRITE r1 = 0x33, then READ r1 → rd_en_n = 0 for exactly one cycle with rd_sel = 1; rsp_data = 0x33; no wr_store during the READ.
- WRITE r3 = 0xF0, then ADD r3 + 0x20 → wr_data = 0x10 on the store pulse, rsp_data = 0x10, rsp_carry = 1, latency 3; a subsequent READ r3 returns 0x10.
- NOP accepted → no response and no strobes; cmd_ready stays 1.
- rsp_ready held low for 5 cycles after READ → rsp_valid/rsp_data stable, cmd_ready 0 throughout; completes one cycle after rsp_ready rises.
- Reset asserted during the READ state of an ADD → no wr_store, no rsp_valid, IDLE next cycle, register contents unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared definitions for the 4-entry register-file command
//               sequencer: default data width, register address width,
//               command op codes and sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DATA_W_DEFAULT = 8;
    localparam int REG_ADDR_W     = 2;

    // Command op codes
    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_ADD   = 2'b11;

    // Sequencer state encoding
    localparam int         ST_W     = 2;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_seq.sv
`default_nettype none
// ============================================================================
// Module      : regfile_seq
// Description : Command sequencer for a 4 x DATA_W register file. Accepts
//               WRITE / READ / ADD commands over valid/ready, drives the
//               write-side demux controls and the read-side 4:1 mux, and
//               returns one response per non-NOP command.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               cmd_*               - command handshake (op, addr, wdata)
//               wr_sel/wr_data/wr_store - data demux + store demux controls
//               rd_sel/rd_en_n/rd_y - read mux select/enable and its output
//               rsp_*               - response handshake (data, carry)
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_seq
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [REG_ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    output logic [REG_ADDR_W-1:0] wr_sel,
    output logic [DATA_W-1:0]     wr_data,
    output logic                  wr_store,
    output logic [REG_ADDR_W-1:0] rd_sel,
    output logic                  rd_en_n,
    input  logic [DATA_W-1:0]     rd_y,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_carry
);

    logic [ST_W-1:0]       r_state;
    logic [ST_W-1:0]       w_next_state;
    logic [1:0]            r_op;
    logic [REG_ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     r_operand;
    logic                  w_accept;
    logic [DATA_W:0]       w_sum;

    assign w_accept = cmd_valid && cmd_ready;

    // One extra bit so the ADD carry-out falls out of the same adder.
    assign w_sum = {1'b0, r_operand} + {1'b0, r_wdata};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (cmd_op)
                        OP_WRITE: w_next_state = ST_WRITE;
                        OP_READ:  w_next_state = ST_READ;
                        OP_ADD:   w_next_state = ST_READ;
                        default:  w_next_state = ST_IDLE;
                    endcase
                end
            end
            ST_READ:  w_next_state = (r_op == OP_ADD) ? ST_WRITE : ST_RESP;
            ST_WRITE: w_next_state = ST_RESP;
            ST_RESP:  w_next_state = rsp_ready ? ST_IDLE : ST_RESP;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Command latch and read operand capture. These hold steady through
    // RESP, which keeps rsp_data/rsp_carry stable under backpressure.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op      <= OP_NOP;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_operand <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= cmd_op;
                r_addr  <= cmd_addr;
                r_wdata <= cmd_wdata;
            end
            if (r_state == ST_READ) begin
                r_operand <= rd_y;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready = 1'b0;
        wr_sel    = '0;
        wr_data   = '0;
        wr_store  = 1'b0;
        rd_sel    = '0;
        rd_en_n   = 1'b1;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_carry = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = !reset;
            end
            ST_READ: begin
                rd_sel  = r_addr;
                rd_en_n = 1'b0;
            end
            ST_WRITE: begin
                wr_sel   = r_addr;
                wr_store = 1'b1;
                wr_data  = (r_op == OP_ADD) ? w_sum[DATA_W-1:0] : r_wdata;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                case (r_op)
                    OP_WRITE: rsp_data = r_wdata;
                    OP_READ:  rsp_data = r_operand;
                    OP_ADD: begin
                        rsp_data  = w_sum[DATA_W-1:0];
                        rsp_carry = w_sum[DATA_W];
                    end
                    default:  rsp_data = '0;
                endcase
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

endmodule : regfile_seq
`default_nettype wire

// File: tb/tb_regfile_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_seq
// Description : Self-checking bench for regfile_seq. Models the register
//               storage, store demux and read mux around the sequencer and
//               applies a table of directed commands plus hand-written
//               sequences for NOP, backpressure and mid-command reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_seq;
    import regfile_pkg::*;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [1:0]    cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [1:0]    wr_sel;
    logic [DW-1:0] wr_data;
    logic          wr_store;
    logic [1:0]    rd_sel;
    logic          rd_en_n;
    logic [DW-1:0] rd_y;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_carry;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_seq #(.DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .wr_store  (wr_store),
        .rd_sel    (rd_sel),
        .rd_en_n   (rd_en_n),
        .rd_y      (rd_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry)
    );

    // Storage, store demux and read mux siblings (not reset by design reset)
    logic [DW-1:0] regs [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    always @(posedge clk) begin
        if (wr_store) regs[wr_sel] <= wr_data;
    end
    assign rd_y = rd_en_n ? '0 : regs[rd_sel];

    // Strobe monitor
    int            n_store = 0;
    int            n_rd    = 0;
    logic [1:0]    last_wsel;
    logic [DW-1:0] last_wdata;
    logic [1:0]    last_rsel;
    always @(negedge clk) begin
        if (wr_store) begin
            n_store    = n_store + 1;
            last_wsel  = wr_sel;
            last_wdata = wr_data;
        end
        if (!rd_en_n) begin
            n_rd      = n_rd + 1;
            last_rsel = rd_sel;
        end
        if (!reset) begin
            checks = checks + 1;
            if (!wr_store && (wr_data != 0 || wr_sel != 0)) begin
                failures = failures + 1;
                $display("FAIL idle_wr_outputs: wr_sel=%0d wr_data=%h required 0", wr_sel, wr_data);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [1:0]    addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_data;
        logic          exp_carry;
        int            exp_lat;
        int            exp_stores;
        logic [DW-1:0] exp_wdata;
        int            exp_reads;
    } vec_t;

    // Issue one command with rsp_ready high, check strobes, latency, response.
    task automatic run_cmd(input vec_t v);
        int  s0, r0, n;
        bit  got;
        @(negedge clk);
        chk("cmd_ready_before", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        s0 = n_store;
        r0 = n_rd;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        n   = 0;
        got = 0;
        while (!got && n < 10) begin
            @(negedge clk);
            n = n + 1;
            if (rsp_valid) got = 1;
        end
        chk("latency", n, v.exp_lat);
        chk("rsp_data", {24'd0, rsp_data}, {24'd0, v.exp_data});
        chk("rsp_carry", {31'd0, rsp_carry}, {31'd0, v.exp_carry});
        chk("store_pulses", n_store - s0, v.exp_stores);
        if (v.exp_stores > 0) begin
            chk("store_sel", {30'd0, last_wsel}, {30'd0, v.addr});
            chk("store_data", {24'd0, last_wdata}, {24'd0, v.exp_wdata});
        end
        chk("read_cycles", n_rd - r0, v.exp_reads);
        if (v.exp_reads > 0) begin
            chk("read_sel", {30'd0, last_rsel}, {30'd0, v.addr});
        end
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [9];

    initial begin
        int s0, r0, n;
        bit got;
        vec_t v;

        //            op        addr  wdata  data   c     lat st  wdata  rd
        vecs[0] = '{OP_WRITE, 2'd2, 8'h5A, 8'h5A, 1'b0, 2, 1, 8'h5A, 0};
        vecs[1] = '{OP_WRITE, 2'd1, 8'h33, 8'h33, 1'b0, 2, 1, 8'h33, 0};
        vecs[2] = '{OP_READ,  2'd1, 8'h00, 8'h33, 1'b0, 2, 0, 8'h00, 1};
        vecs[3] = '{OP_WRITE, 2'd3, 8'hF0, 8'hF0, 1'b0, 2, 1, 8'hF0, 0};
        vecs[4] = '{OP_ADD,   2'd3, 8'h20, 8'h10, 1'b1, 3, 1, 8'h10, 1};
        vecs[5] = '{OP_READ,  2'd3, 8'h00, 8'h10, 1'b0, 2, 0, 8'h00, 1};
        vecs[6] = '{OP_ADD,   2'd0, 8'h01, 8'h01, 1'b0, 3, 1, 8'h01, 1};
        vecs[7] = '{OP_READ,  2'd2, 8'h00, 8'h5A, 1'b0, 2, 0, 8'h00, 1};
        vecs[8] = '{OP_ADD,   2'd2, 8'hFF, 8'h59, 1'b1, 3, 1, 8'h59, 1};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;

        // Reset behaviour
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rd_en_n", {31'd0, rd_en_n}, 32'd1);
        chk("reset_wr_store", {31'd0, wr_store}, 32'd0);
        chk("reset_rsp_data", {24'd0, rsp_data}, 32'd0);

        // Directed command table
        for (int i = 0; i < 9; i++) begin
            run_cmd(vecs[i]);
        end

        // NOP: no response, no strobes, stays ready
        @(negedge clk);
        s0 = n_store;
        r0 = n_rd;
        cmd_valid = 1'b1;
        cmd_op    = OP_NOP;
        cmd_addr  = 2'd1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        got = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid || !cmd_ready) got = 1;
        end
        chk("nop_quiet", {31'd0, got}, 32'd0);
        chk("nop_strobes", (n_store - s0) + (n_rd - r0), 0);

        // Backpressure on a READ of r1 (0x33)
        rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_READ;
        cmd_addr  = 2'd1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        n = 0;
        got = 0;
        while (!got && n < 10) begin
            @(negedge clk);
            n = n + 1;
            if (rsp_valid) got = 1;
        end
        chk("bp_latency", n, 2);
        got = 0;
        for (int k = 0; k < 5; k++) begin
            if (!rsp_valid || rsp_data != 8'h33 || rsp_carry || cmd_ready) got = 1;
            @(negedge clk);
        end
        chk("bp_stable", {31'd0, got}, 32'd0);
        rsp_ready = 1'b1;
        chk("bp_still_valid", {31'd0, rsp_valid}, 32'd1);
        @(negedge clk);
        chk("bp_done_valid", {31'd0, rsp_valid}, 32'd0);
        chk("bp_done_ready", {31'd0, cmd_ready}, 32'd1);

        // Reset during the READ state of an ADD to r3
        @(negedge clk);
        s0 = n_store;
        cmd_valid = 1'b1;
        cmd_op    = OP_ADD;
        cmd_addr  = 2'd3;
        cmd_wdata = 8'h55;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        @(negedge clk);
        chk("rst_in_read_state", {31'd0, rd_en_n}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_idle_ready", {31'd0, cmd_ready}, 32'd1);
        got = 0;
        for (int k = 0; k < 4; k++) begin
            if (rsp_valid) got = 1;
            @(negedge clk);
        end
        chk("rst_no_rsp", {31'd0, got}, 32'd0);
        chk("rst_no_store", n_store - s0, 0);
        v = '{OP_READ, 2'd3, 8'h00, 8'h10, 1'b0, 2, 0, 8'h00, 1};
        run_cmd(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_regfile_seq
`default_nettype wire
